seat_lease_tracker: RTL and testbench

Consumer of the library timer. Tracks per-seat occupancy leases in minutes, driven by the timer's one-minute tick and daily reset indication. Accepts reserve, extend, release and query commands from the seat-control front end. Emits expiry events when a lease runs out.

---
 rtl/seat_lease_tracker.sv | 216 +++++++++++++++++++++
 tb/tb_seat_lease_tracker.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seat_lease_tracker.sv
// Per-seat lease tracker: minute-based leases with reserve/extend/release/query, expiry scan and daily clear.
// Optional SEAT_LEASE_WARN_EN adds a WARN_MIN parameter and a warn_valid/warn_seat pulse during scans.
module seat_lease_tracker #(
  parameter int NUM_SEATS = 16,
  parameter int LEASE_MIN = 120,
  parameter int EXT_MIN   = 60,
  parameter int MAX_EXT   = 2,
`ifdef SEAT_LEASE_WARN_EN
  parameter int WARN_MIN  = 10,
`endif
  localparam int SEAT_W   = $clog2(NUM_SEATS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              min_tick,
  input  logic              day_reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [SEAT_W-1:0] cmd_seat,
  output logic              rsp_valid,
  output logic              rsp_ok,
  output logic [NUM_SEATS-1:0] occupied,
  output logic [SEAT_W:0]   free_count,
  output logic              expire_valid,
  output logic [SEAT_W-1:0] expire_seat
`ifdef SEAT_LEASE_WARN_EN
  ,
  output logic              warn_valid,
  output logic [SEAT_W-1:0] warn_seat
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, CLEAR} state_t;

  localparam logic [SEAT_W:0]   NUM_SEATS_W = (SEAT_W+1)'(NUM_SEATS);
  localparam logic [SEAT_W-1:0] LAST_IDX    = SEAT_W'(NUM_SEATS - 1);
  localparam logic [7:0]        LEASE_W     = 8'(LEASE_MIN);
  localparam logic [8:0]        EXT_W       = 9'(EXT_MIN);
  localparam logic [1:0]        MAX_EXT_W   = 2'(MAX_EXT);
  localparam logic [1:0]        OP_RESERVE  = 2'b00;
  localparam logic [1:0]        OP_EXTEND   = 2'b01;
  localparam logic [1:0]        OP_RELEASE  = 2'b10;

  state_t                 state_q;
  logic [NUM_SEATS-1:0]   occupied_q;
  logic [SEAT_W:0]        freeCount_q;
  logic [7:0]             remaining_q [NUM_SEATS];
  logic [1:0]             ext_q       [NUM_SEATS];
  logic [SEAT_W-1:0]      scanIdx_q;
  logic                   pending_q;
  logic                   dayReset_q;
  logic                   rspValid_q;
  logic                   rspOk_q;
  logic                   expireValid_q;
  logic [SEAT_W-1:0]      expireSeat_q;
`ifdef SEAT_LEASE_WARN_EN
  logic                   warnValid_q;
  logic [SEAT_W-1:0]      warnSeat_q;
`endif

  logic                   dayEdge;
  logic                   cmdFire;
  logic                   seatInRange;
  logic                   cmdSeatOcc;
  logic [8:0]             extSum_d;
  logic [7:0]             extRem_d;
  logic [7:0]             scanRem;

  assign dayEdge     = day_reset && !dayReset_q;
  assign cmd_ready   = (state_q == IDLE) && !pending_q && !dayEdge;
  assign cmdFire     = cmd_valid && cmd_ready;
  assign seatInRange = {1'b0, cmd_seat} < NUM_SEATS_W;
  assign cmdSeatOcc  = seatInRange && occupied_q[cmd_seat];
  assign scanRem     = remaining_q[scanIdx_q];

  // Out-of-range seats are never read because every use is gated by seatInRange.
  always_comb begin
    extSum_d = 9'd0;
    extRem_d = 8'd0;
    if (seatInRange) begin
      extSum_d = {1'b0, remaining_q[cmd_seat]} + EXT_W;
      extRem_d = extSum_d[8] ? 8'hFF : extSum_d[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      occupied_q    <= '0;
      freeCount_q   <= NUM_SEATS_W;
      scanIdx_q     <= '0;
      pending_q     <= 1'b0;
      dayReset_q    <= 1'b0;
      rspValid_q    <= 1'b0;
      rspOk_q       <= 1'b0;
      expireValid_q <= 1'b0;
      expireSeat_q  <= '0;
`ifdef SEAT_LEASE_WARN_EN
      warnValid_q   <= 1'b0;
      warnSeat_q    <= '0;
`endif
      for (int i = 0; i < NUM_SEATS; i++) begin
        remaining_q[i] <= 8'd0;
        ext_q[i]       <= 2'd0;
      end
    end else begin
      dayReset_q    <= day_reset;
      rspValid_q    <= 1'b0;
      rspOk_q       <= 1'b0;
      expireValid_q <= 1'b0;
`ifdef SEAT_LEASE_WARN_EN
      warnValid_q   <= 1'b0;
`endif
      if (dayEdge) begin
        // Daily clear wins over everything; a coincident tick is simply dropped.
        state_q     <= CLEAR;
        occupied_q  <= '0;
        freeCount_q <= NUM_SEATS_W;
        scanIdx_q   <= '0;
        pending_q   <= 1'b0;
        for (int i = 0; i < NUM_SEATS; i++) begin
          remaining_q[i] <= 8'd0;
          ext_q[i]       <= 2'd0;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (cmdFire) begin
              rspValid_q <= 1'b1;
              case (cmd_op)
                OP_RESERVE: begin
                  if (seatInRange && !cmdSeatOcc) begin
                    rspOk_q                <= 1'b1;
                    occupied_q[cmd_seat]   <= 1'b1;
                    freeCount_q            <= freeCount_q - 1'b1;
                    remaining_q[cmd_seat]  <= LEASE_W;
                    ext_q[cmd_seat]        <= 2'd0;
                  end
                end
                OP_EXTEND: begin
                  if (cmdSeatOcc && (ext_q[cmd_seat] < MAX_EXT_W)) begin
                    rspOk_q               <= 1'b1;
                    remaining_q[cmd_seat] <= extRem_d;
                    ext_q[cmd_seat]       <= ext_q[cmd_seat] + 2'd1;
                  end
                end
                OP_RELEASE: begin
                  if (cmdSeatOcc) begin
                    rspOk_q               <= 1'b1;
                    occupied_q[cmd_seat]  <= 1'b0;
                    freeCount_q           <= freeCount_q + 1'b1;
                    remaining_q[cmd_seat] <= 8'd0;
                    ext_q[cmd_seat]       <= 2'd0;
                  end
                end
                default: rspOk_q <= cmdSeatOcc;
              endcase
            end
            if (min_tick) begin
              state_q   <= SCAN;
              scanIdx_q <= '0;
            end
          end
          SCAN: begin
            if (occupied_q[scanIdx_q]) begin
              if (scanRem == 8'd1) begin
                occupied_q[scanIdx_q]  <= 1'b0;
                freeCount_q            <= freeCount_q + 1'b1;
                remaining_q[scanIdx_q] <= 8'd0;
                ext_q[scanIdx_q]       <= 2'd0;
                expireValid_q          <= 1'b1;
                expireSeat_q           <= scanIdx_q;
              end else begin
                remaining_q[scanIdx_q] <= scanRem - 8'd1;
`ifdef SEAT_LEASE_WARN_EN
                if (scanRem - 8'd1 == 8'(WARN_MIN)) begin
                  warnValid_q <= 1'b1;
                  warnSeat_q  <= scanIdx_q;
                end
`endif
              end
            end
            // A tick arriving on the final visit still counts as pending.
            if (scanIdx_q == LAST_IDX) begin
              scanIdx_q <= '0;
              pending_q <= 1'b0;
              if (!(pending_q || min_tick)) begin
                state_q <= IDLE;
              end
            end else begin
              scanIdx_q <= scanIdx_q + 1'b1;
              if (min_tick) begin
                pending_q <= 1'b1;
              end
            end
          end
          CLEAR: state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rsp_valid    = rspValid_q;
  assign rsp_ok       = rspOk_q;
  assign occupied     = occupied_q;
  assign free_count   = freeCount_q;
  assign expire_valid = expireValid_q;
  assign expire_seat  = expireSeat_q;
`ifdef SEAT_LEASE_WARN_EN
  assign warn_valid   = warnValid_q;
  assign warn_seat    = warnSeat_q;
`endif

endmodule

// File: tb/tb_seat_lease_tracker.sv
// Directed bench for seat_lease_tracker with NUM_SEATS=6, LEASE_MIN=3, EXT_MIN=2, MAX_EXT=1.
module tb_seat_lease_tracker;

  logic       clk;
  logic       rst;
  logic       min_tick;
  logic       day_reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_seat;
  logic       rsp_valid;
  logic       rsp_ok;
  logic [5:0] occupied;
  logic [3:0] free_count;
  logic       expire_valid;
  logic [2:0] expire_seat;

  int errors = 0;
  int checks = 0;
  int expCount = 0;
  int lastExpSeat = 0;
  int lowCount = 0;
  int expBase;

  typedef struct {
    logic [1:0] op;
    logic [2:0] seat;
    logic       expOk;
    logic [5:0] expOcc;
    logic [3:0] expFree;
  } vec_t;

  vec_t vecs [13];

  seat_lease_tracker #(
    .NUM_SEATS(6), .LEASE_MIN(3), .EXT_MIN(2), .MAX_EXT(1)
  ) dut (
    .clk(clk), .rst(rst), .min_tick(min_tick), .day_reset(day_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_seat(cmd_seat),
    .rsp_valid(rsp_valid), .rsp_ok(rsp_ok), .occupied(occupied), .free_count(free_count),
    .expire_valid(expire_valid), .expire_seat(expire_seat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Background observer: counts expire pulse cycles and cmd_ready-low cycles.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (expire_valid) begin
        expCount++;
        lastExpSeat = int'(expire_seat);
      end
      if (!cmd_ready) lowCount++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [2:0] seat);
    int waitCnt;
    waitCnt = 0;
    @(negedge clk);
    while (!cmd_ready && waitCnt < 40) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_seat  = seat;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic pulseTick(input int gap);
    @(negedge clk);
    min_tick = 1'b1;
    @(negedge clk);
    min_tick = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{2'b00, 3'd2, 1'b1, 6'b000100, 4'd5};
    vecs[1]  = '{2'b00, 3'd2, 1'b0, 6'b000100, 4'd5};
    vecs[2]  = '{2'b00, 3'd7, 1'b0, 6'b000100, 4'd5};
    vecs[3]  = '{2'b11, 3'd2, 1'b1, 6'b000100, 4'd5};
    vecs[4]  = '{2'b11, 3'd3, 1'b0, 6'b000100, 4'd5};
    vecs[5]  = '{2'b01, 3'd3, 1'b0, 6'b000100, 4'd5};
    vecs[6]  = '{2'b10, 3'd3, 1'b0, 6'b000100, 4'd5};
    vecs[7]  = '{2'b00, 3'd5, 1'b1, 6'b100100, 4'd4};
    vecs[8]  = '{2'b01, 3'd5, 1'b1, 6'b100100, 4'd4};
    vecs[9]  = '{2'b01, 3'd5, 1'b0, 6'b100100, 4'd4};
    vecs[10] = '{2'b10, 3'd5, 1'b1, 6'b000100, 4'd5};
    vecs[11] = '{2'b10, 3'd6, 1'b0, 6'b000100, 4'd5};
    vecs[12] = '{2'b11, 3'd7, 1'b0, 6'b000100, 4'd5};

    rst = 1'b1; min_tick = 1'b0; day_reset = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_seat = 3'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_occupied", {26'd0, occupied}, 32'd0);
    checkOutput("reset_free", {28'd0, free_count}, 32'd6);
    checkOutput("reset_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("reset_expire", {31'd0, expire_valid}, 32'd0);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].op, vecs[i].seat);
      checkOutput($sformatf("vec%0d_rsp_valid", i), {31'd0, rsp_valid}, 32'd1);
      checkOutput($sformatf("vec%0d_rsp_ok", i), {31'd0, rsp_ok}, {31'd0, vecs[i].expOk});
      checkOutput($sformatf("vec%0d_occ", i), {26'd0, occupied}, {26'd0, vecs[i].expOcc});
      checkOutput($sformatf("vec%0d_free", i), {28'd0, free_count}, {28'd0, vecs[i].expFree});
    end
    @(posedge clk); #1;
    checkOutput("rsp_pulse_ends", {31'd0, rsp_valid}, 32'd0);

    // Seat 2 holds a 3-minute lease: expires on the third scan.
    pulseTick(20);
    checkOutput("t3_tick1_noexp", expCount, 0);
    pulseTick(20);
    checkOutput("t3_tick2_noexp", expCount, 0);
    pulseTick(20);
    checkOutput("t3_tick3_exp", expCount, 1);
    checkOutput("t3_exp_seat", lastExpSeat, 2);
    checkOutput("t3_occ", {26'd0, occupied}, 32'd0);
    checkOutput("t3_free", {28'd0, free_count}, 32'd6);

    // Extend after one tick: 2 + 2 = 4 minutes left, second extend refused.
    applyStimulus(2'b00, 3'd1);
    checkOutput("t4_reserve_ok", {31'd0, rsp_ok}, 32'd1);
    pulseTick(20);
    applyStimulus(2'b01, 3'd1);
    checkOutput("t4_ext1_ok", {31'd0, rsp_ok}, 32'd1);
    applyStimulus(2'b01, 3'd1);
    checkOutput("t4_ext2_refused", {31'd0, rsp_ok}, 32'd0);
    for (int t = 1; t <= 3; t++) begin
      pulseTick(20);
      checkOutput($sformatf("t4_tick%0d_noexp", t), expCount, 1);
    end
    pulseTick(20);
    checkOutput("t4_tick4_exp", expCount, 2);
    checkOutput("t4_exp_seat", lastExpSeat, 1);
    checkOutput("t4_occ", {26'd0, occupied}, 32'd0);

    // Back-to-back scans: ticks at P1 and P3 run two scans, tick at P5 is lost.
    applyStimulus(2'b00, 3'd0);
    checkOutput("t5_reserve_ok", {31'd0, rsp_ok}, 32'd1);
    @(negedge clk);
    lowCount = 0;
    min_tick = 1'b1;
    @(negedge clk); min_tick = 1'b0;
    @(negedge clk); min_tick = 1'b1;
    @(negedge clk); min_tick = 1'b0;
    @(negedge clk); min_tick = 1'b1;
    @(negedge clk); min_tick = 1'b0;
    repeat (25) @(negedge clk);
    checkOutput("t5_ready_low_cycles", lowCount, 12);
    checkOutput("t5_noexp", expCount, 2);
    checkOutput("t5_still_occ", {26'd0, occupied}, 32'd1);
    pulseTick(20);
    checkOutput("t5_exp_after_one_more", expCount, 3);
    checkOutput("t5_exp_seat", lastExpSeat, 0);

    // Daily clear with day_reset held high.
    applyStimulus(2'b00, 3'd0);
    applyStimulus(2'b00, 3'd3);
    checkOutput("t6_occ_before", {26'd0, occupied}, 32'h09);
    @(negedge clk);
    day_reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("t6_occ_cleared", {26'd0, occupied}, 32'd0);
    checkOutput("t6_free_cleared", {28'd0, free_count}, 32'd6);
    checkOutput("t6_ready_in_clear", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    checkOutput("t6_ready_after_clear", {31'd0, cmd_ready}, 32'd1);
    applyStimulus(2'b00, 3'd4);
    checkOutput("t6_reserve_high_ok", {31'd0, rsp_ok}, 32'd1);
    pulseTick(20);
    pulseTick(20);
    checkOutput("t6_no_reclear", {26'd0, occupied}, 32'h10);
    checkOutput("t6_no_clear_exp", expCount, 3);
    pulseTick(20);
    checkOutput("t6_exp_count", expCount, 4);
    checkOutput("t6_exp_seat", lastExpSeat, 4);

    @(negedge clk);
    day_reset = 1'b0;
    applyStimulus(2'b00, 3'd1);
    checkOutput("t6_occ_seat1", {26'd0, occupied}, 32'h02);
    @(negedge clk);
    day_reset = 1'b1;
    min_tick  = 1'b1;
    @(posedge clk); #1;
    min_tick = 1'b0;
    checkOutput("t6_reclear_occ", {26'd0, occupied}, 32'd0);
    @(posedge clk); #1;
    checkOutput("t6_tick_dropped_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (10) @(negedge clk);
    checkOutput("t6_final_exp", expCount, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
